// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD result readback path.
package simd_pkg;

  localparam int unsigned DEF_PE_COUNT   = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RD_LATENCY = 2;

  typedef logic [DEF_DATA_WIDTH-1:0]                    lane_t;
  typedef logic [DEF_PE_COUNT-1:0][DEF_DATA_WIDTH-1:0]  row_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } streamer_state_e;

endpackage

// File: rtl/simd_result_streamer_if.sv
// Valid/ready row stream from the result streamer to the host-side sink.
interface simd_result_streamer_if #(
  parameter int unsigned PE_COUNT       = simd_pkg::DEF_PE_COUNT,
  parameter int unsigned DATA_WIDTH     = simd_pkg::DEF_DATA_WIDTH,
  parameter int unsigned INS_ADDR_WIDTH = 11
);

  logic                           m_valid;
  logic                           m_ready;
  logic [PE_COUNT*DATA_WIDTH-1:0] m_data;
  logic [INS_ADDR_WIDTH-1:0]      m_addr;
  logic                           m_last;

  modport master (output m_valid, m_data, m_addr, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_addr, m_last, output m_ready);

endinterface

// File: rtl/simd_row_fifo.sv
// Synchronous FIFO for {row, addr, last} entries; DEPTH must be a power of two.
module simd_row_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntFull);
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/simd_result_streamer.sv
// Readback engine for result BRAM R: sweeps an address window after out_data_valid,
// absorbs the BRAM read latency and streams one PE row per beat with backpressure.
// Optional RESULT_CHECKSUM_EN adds a running lane-sum output `checksum`.
module simd_result_streamer #(
  parameter int unsigned PE_COUNT       = simd_pkg::DEF_PE_COUNT,
  parameter int unsigned DATA_WIDTH     = simd_pkg::DEF_DATA_WIDTH,
  parameter int unsigned INS_ADDR_WIDTH = 11,
  parameter int unsigned RD_LATENCY     = simd_pkg::DEF_RD_LATENCY,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [INS_ADDR_WIDTH-1:0]      base_addr,
  input  logic [INS_ADDR_WIDTH:0]        row_count,
  input  logic                           out_data_valid,
  output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  simd_result_streamer_if.master         m,
  output logic                           busy,
  output logic                           done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]          checksum
`endif
);

  import simd_pkg::*;

  localparam int unsigned RowW     = PE_COUNT * DATA_WIDTH;
  localparam int unsigned EntW     = RowW + INS_ADDR_WIDTH + 1;
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [INS_ADDR_WIDTH:0]   RowOne  = 1;
  localparam logic [INS_ADDR_WIDTH-1:0] AddrOne = 1;

  streamer_state_e state_q, state_d;

  logic [INS_ADDR_WIDTH-1:0] addr_q, rd_addr_q;
  logic [INS_ADDR_WIDTH:0]   remain_q;
  logic [RD_LATENCY-1:0]     tag_vld_q, tag_last_q;
  logic [INS_ADDR_WIDTH-1:0] tag_addr_q [RD_LATENCY];

  logic                start_ok, issue, pop, push;
  logic                fifo_empty, fifo_full;
  logic [FifoCntW-1:0] fifo_count;
  logic [EntW-1:0]     fifo_wdata, fifo_rdata;
  logic [CntW-1:0]     in_flight, occ;
  logic [RowW-1:0]     head_row;

  assign start_ok = (state_q == IDLE) && start;
  assign pop      = !fifo_empty && m.m_ready;
  assign push     = tag_vld_q[RD_LATENCY-1];

  // Credit check: occupancy after this cycle's pop must leave room for one more row.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CntW'(tag_vld_q[i]);
    occ = in_flight + CntW'(fifo_count) - CntW'(pop);
  end

  assign issue = (state_q == ISSUE) && (remain_q != '0) && (occ < CntW'(FIFO_DEPTH));

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (out_data_valid) state_d = (remain_q != '0) ? ISSUE : FIN;
      ISSUE:   if (issue && (remain_q == RowOne)) state_d = DRAIN;
      // With nothing in flight, occ is the FIFO level after this cycle's pop.
      DRAIN:   if ((in_flight == '0) && (occ == '0)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, window counters and the held read address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q   <= base_addr;
        remain_q <= row_count;
      end else if (issue) begin
        addr_q   <= addr_q + AddrOne;
        remain_q <= remain_q - RowOne;
      end
      if (issue) rd_addr_q <= addr_q;
    end
  end

  // Tag shift register tracking each read until its data appears on bram_r_r_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_addr_q[i] <= '0;
    end else begin
      tag_vld_q[0]  <= issue;
      tag_last_q[0] <= (remain_q == RowOne);
      tag_addr_q[0] <= addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  assign fifo_wdata = {bram_r_r_data, tag_addr_q[RD_LATENCY-1], tag_last_q[RD_LATENCY-1]};

  simd_row_fifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Gate the head so stale storage never shows while the stream is idle.
  assign head_row      = fifo_empty ? '0 : fifo_rdata[EntW-1 -: RowW];
  assign m.m_valid     = !fifo_empty;
  assign m.m_data      = head_row;
  assign m.m_addr      = fifo_empty ? '0 : fifo_rdata[INS_ADDR_WIDTH:1];
  assign m.m_last      = !fifo_empty && fifo_rdata[0];
  assign bram_r_r_addr = rd_addr_q;
  assign busy          = (state_q == WAIT) || (state_q == ISSUE) || (state_q == DRAIN);
  assign done          = (state_q == FIN);

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q, row_sum;

  // Lane sum of the row being popped.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < PE_COUNT; i++) row_sum = row_sum + head_row[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Running checksum, cleared by an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         cksum_q <= '0;
    else if (start_ok) cksum_q <= '0;
    else if (pop)      cksum_q <= cksum_q + row_sum;
  end

  assign checksum = cksum_q;
`endif

`ifndef SYNTHESIS
  // Credits guarantee a free entry for every returning read.
  push_never_full: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));
`endif

endmodule
